// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions.
// Contents:
//   - receiver state encoding
//   - default bit period
//   - synchroniser depth
//   - 8N1 frame constants
// Ports: none (package).
// ---------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      DONE,
      TURN
   } rx_state_t;

   localparam int unsigned DEF_BIT_CLKS = 434;   // 50 MHz / 115200 baud
   localparam int unsigned SYNC_STAGES  = 2;
   localparam int unsigned DATA_BITS    = 8;
   localparam logic        STOP_LEVEL   = 1'b1;

endpackage

// File: rtl/rx_funcmod_if.sv
// ---------------------------------------------------------------------------
// rx_funcmod_if
// Call/done handshake between a stepped caller and rx_funcmod.
// Signals:
//   iCall  caller request, held high until oDone is seen
//   oDone  one-cycle completion pulse
//   oData  received byte
//   oErr   framing error, valid with oDone
// Modports:
//   master  the caller
//   slave   the receiver
// ---------------------------------------------------------------------------
interface rx_funcmod_if;
   import uart_pkg::*;

   logic                 iCall;
   logic                 oDone;
   logic [DATA_BITS-1:0] oData;
   logic                 oErr;

   modport master (output iCall, input  oDone, oData, oErr);
   modport slave  (input  iCall, output oDone, oData, oErr);

endinterface

// File: rtl/rx_sync_edge.sv
// ---------------------------------------------------------------------------
// rx_sync_edge
// Synchronises the asynchronous serial input to CLOCK and detects falling
// edges on the synchronised line.
// Ports:
//   CLOCK  system clock
//   RESET  asynchronous, active-low reset
//   RXD    raw serial input, idle high
//   rxs    synchronised line level (reset 1)
//   fall   high for the one cycle in which rxs goes 1->0 (reset 0)
// ---------------------------------------------------------------------------
module rx_sync_edge
   import uart_pkg::*;
(
   input  logic CLOCK,
   input  logic RESET,
   input  logic RXD,
   output logic rxs,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   rxs_prev;

   // Reset to the idle level so that leaving reset never looks like an edge.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         sync     <= '1;
         rxs_prev <= 1'b1;
      end else begin
         sync     <= {sync[SYNC_STAGES-2:0], RXD};
         rxs_prev <= sync[SYNC_STAGES-1];
      end
   end

   assign rxs  = sync[SYNC_STAGES-1];
   assign fall = rxs_prev & ~rxs;

endmodule

// File: rtl/rx_funcmod.sv
// ---------------------------------------------------------------------------
// rx_funcmod
// UART receiver function module, 8N1, LSB first.
// One iCall/oDone call returns one received byte.
// Parameters:
//   BIT_CLKS   clocks per bit period (>= 8)
//   HALF_CLKS  clocks from the detected start edge to the start-bit middle
// Ports:
//   CLOCK  system clock
//   RESET  asynchronous, active-low reset
//   RXD    serial input, idle high, asynchronous to CLOCK
//   bus    slave side of rx_funcmod_if
//            iCall  request, held high until oDone
//            oDone  one-cycle pulse
//            oData  byte, held until the next completed frame
//            oErr   framing error (stop bit sampled low)
// ---------------------------------------------------------------------------
module rx_funcmod
   import uart_pkg::*;
#(
   parameter int unsigned BIT_CLKS  = DEF_BIT_CLKS,
   parameter int unsigned HALF_CLKS = BIT_CLKS / 2
)
(
   input  logic         CLOCK,
   input  logic         RESET,
   input  logic         RXD,
   rx_funcmod_if.slave  bus
);

   localparam int unsigned CW = $clog2(BIT_CLKS);
   localparam int unsigned IW = $clog2(DATA_BITS);

   localparam logic [CW-1:0] BIT_TC   = CW'(BIT_CLKS - 1);
   localparam logic [CW-1:0] HALF_TC  = CW'(HALF_CLKS - 1);
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

   rx_state_t            state;
   rx_state_t            nxt;
   logic [CW-1:0]        cnt;
   logic [IW-1:0]        idx;
   logic [DATA_BITS-1:0] shift;
   logic                 rxs;
   logic                 fall;

   logic cnt_clr;
   logic cnt_inc;
   logic idx_clr;
   logic smp_data;
   logic smp_stop;
   logic done;

   rx_sync_edge u_sync (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .RXD   (RXD),
      .rxs   (rxs),
      .fall  (fall)
   );

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET)
         state <= IDLE;
      else
         state <= nxt;
   end

   // An abort from iCall takes priority over a sample due in the same cycle.
   // The counter only advances below its terminal count, so it saturates.
   always_comb begin
      nxt      = state;
      cnt_clr  = 1'b0;
      cnt_inc  = 1'b0;
      idx_clr  = 1'b0;
      smp_data = 1'b0;
      smp_stop = 1'b0;
      done     = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.iCall && fall) begin
               nxt     = START;
               cnt_clr = 1'b1;
            end
         end
         START: begin
            if (!bus.iCall) begin
               nxt = IDLE;
            end else if (cnt == HALF_TC) begin
               if (rxs) begin
                  nxt = IDLE;
               end else begin
                  nxt     = DATA;
                  cnt_clr = 1'b1;
                  idx_clr = 1'b1;
               end
            end else begin
               cnt_inc = 1'b1;
            end
         end
         DATA: begin
            if (!bus.iCall) begin
               nxt = IDLE;
            end else if (cnt == BIT_TC) begin
               smp_data = 1'b1;
               cnt_clr  = 1'b1;
               if (idx == LAST_BIT)
                  nxt = STOP;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         STOP: begin
            if (!bus.iCall) begin
               nxt = IDLE;
            end else if (cnt == BIT_TC) begin
               smp_stop = 1'b1;
               nxt      = DONE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         DONE: begin
            done = 1'b1;
            nxt  = TURN;
         end
         TURN: begin
            nxt = IDLE;
         end
         default: begin
            nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         cnt       <= '0;
         idx       <= '0;
         shift     <= '0;
         bus.oData <= '0;
         bus.oErr  <= 1'b0;
      end else begin
         if (cnt_clr)
            cnt <= '0;
         else if (cnt_inc)
            cnt <= cnt + 1'b1;

         if (idx_clr)
            idx <= '0;
         else if (smp_data)
            idx <= idx + 1'b1;

         if (smp_data)
            shift[idx] <= rxs;

         if (smp_stop) begin
            bus.oData <= shift;
            bus.oErr  <= (rxs != STOP_LEVEL);
         end
      end
   end

   assign bus.oDone = done;

endmodule

// File: tb/tb_rx_funcmod.sv
// ---------------------------------------------------------------------------
// tb_rx_funcmod
// Self-checking bench for rx_funcmod with BIT_CLKS = 16.
// A serial driver plays the transmitter. A frame-level model predicts, for
// each frame that should be accepted:
//   - the byte
//   - the error flag
//   - the cycle oDone must appear in
// Between pulses, the outputs must hold the last predicted values.
// ---------------------------------------------------------------------------
module tb_rx_funcmod;

   localparam int unsigned BIT      = 16;
   localparam int unsigned HALF     = BIT / 2;
   localparam int unsigned SYNC_LAT = 2;
   // Cycles from driving the start bit to the oDone cycle.
   localparam int unsigned DONE_LAT = SYNC_LAT + HALF + 9 * BIT + 1;

   logic CLOCK = 1'b0;
   logic RESET = 1'b0;
   logic RXD   = 1'b1;

   rx_funcmod_if bus ();

   rx_funcmod #(.BIT_CLKS(BIT)) dut (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .RXD   (RXD),
      .bus   (bus)
   );

   always #5 CLOCK = ~CLOCK;

   int unsigned n_cmp = 0;
   int unsigned n_mis = 0;
   int unsigned cyc   = 0;

   always @(posedge CLOCK) cyc <= cyc + 1;

   typedef struct {
      logic [7:0]  d;
      logic        e;
      int unsigned t;
   } exp_t;

   exp_t       expq[$];
   logic [7:0] last_d = 8'h00;
   logic       last_e = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, want, cyc);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) begin
         @(posedge CLOCK);
         #1;
      end
   endtask

   always @(negedge CLOCK) begin : mon
      exp_t x;
      if (bus.oDone === 1'b1) begin
         if (expq.size() == 0) begin
            check("spurious_done", 32'(bus.oDone), 32'd0);
         end else begin
            x = expq.pop_front();
            check("data",       32'(bus.oData), 32'(x.d));
            check("err",        32'(bus.oErr),  32'(x.e));
            check("done_cycle", cyc,            x.t);
            last_d = x.d;
            last_e = x.e;
         end
      end else begin
         check("hold_data", 32'(bus.oData), 32'(last_d));
         check("hold_err",  32'(bus.oErr),  32'(last_e));
      end
   end

   // act: 0 none, 1 drop iCall, 2 assert RESET; applied mid-way through
   // data bit act_bit. RESET is held until the frame has finished.
   task automatic send_frame(input logic [7:0] d, input logic stop,
                             input int act_bit, input int act);
      int unsigned t0;
      t0 = cyc;
      if (bus.iCall && act == 0)
         expq.push_back('{d, ~stop, t0 + DONE_LAT});
      RXD = 1'b0;
      tick(BIT);
      for (int i = 0; i < 8; i++) begin
         RXD = d[i];
         if (i == act_bit) begin
            tick(HALF);
            if (act == 1) begin
               bus.iCall = 1'b0;
            end else if (act == 2) begin
               RESET  = 1'b0;
               last_d = 8'h00;
               last_e = 1'b0;
               #1;
               check("rst_mid_done", 32'(bus.oDone), 32'd0);
               check("rst_mid_data", 32'(bus.oData), 32'd0);
               check("rst_mid_err",  32'(bus.oErr),  32'd0);
            end
            tick(BIT - HALF);
         end else begin
            tick(BIT);
         end
      end
      RXD = stop;
      tick(BIT);
      RXD = 1'b1;
      if (act == 2) begin
         tick(2);
         RESET = 1'b1;
      end
   endtask

   initial begin
      logic [7:0]  rd;
      logic        rs;
      int unsigned gap;

      bus.iCall = 1'b0;
      tick(3);
      check("rst_done", 32'(bus.oDone), 32'd0);
      check("rst_data", 32'(bus.oData), 32'd0);
      check("rst_err",  32'(bus.oErr),  32'd0);
      RESET = 1'b1;
      tick(2 * BIT);

      // Back-to-back loopback frames with iCall held.
      bus.iCall = 1'b1;
      send_frame(8'hA1, 1'b1, -1, 0);
      send_frame(8'hA2, 1'b1, -1, 0);
      send_frame(8'hA3, 1'b1, -1, 0);
      tick(BIT);

      // Short low glitch, then a valid frame.
      RXD = 1'b0;
      tick(5);
      RXD = 1'b1;
      tick(3 * BIT);
      send_frame(8'h55, 1'b1, -1, 0);
      tick(BIT);

      // Framing error, then a good frame.
      send_frame(8'h3C, 1'b0, -1, 0);
      tick(BIT);
      send_frame(8'hC3, 1'b1, -1, 0);
      tick(BIT);

      // Break: one error pulse with zero data, no retrigger.
      expq.push_back('{8'h00, 1'b1, cyc + DONE_LAT});
      RXD = 1'b0;
      tick(30 * BIT);
      RXD = 1'b1;
      tick(2 * BIT);

      // Frame while not called: ignored.
      bus.iCall = 1'b0;
      send_frame(8'h5A, 1'b1, -1, 0);
      tick(BIT);
      bus.iCall = 1'b1;
      tick(BIT);

      // Abort by dropping iCall during d3.
      send_frame(8'h96, 1'b1, 3, 1);
      tick(BIT);
      bus.iCall = 1'b1;
      tick(BIT);

      // Reset during d5, then a clean frame.
      send_frame(8'h69, 1'b1, 5, 2);
      tick(BIT);
      send_frame(8'h81, 1'b1, -1, 0);
      tick(BIT);

      // Random frames with occasional bad stop bits and random idle gaps.
      for (int n = 0; n < 16; n++) begin
         rd = 8'($urandom_range(0, 255));
         rs = ($urandom_range(0, 5) != 0);
         send_frame(rd, rs, -1, 0);
         gap = rs ? $urandom_range(0, BIT) : BIT + $urandom_range(0, BIT);
         tick(gap);
      end

      for (int w = 0; w < 20 * BIT && expq.size() != 0; w++)
         tick(1);
      check("pending_frames", expq.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
